univ_sync_fifo_prog: RTL and testbench
======================================

// Module: univ_sync_fifo_prog
// PURPOSE
//  Next-generation single-clock FIFO: parametrised width/depth, fill count, programmable
//  almost-full/almost-empty thresholds, sticky overflow/underflow flags and synchronous flush.
//  Drop-in buffer between producer/consumer blocks sharing one clock; cs gates all accesses.
// PARAMETERS
//  FIFO_DEPTH  8   entries; power of two, >=2
//  DATA_WIDTH  32  bits per entry
//  AF_LEVEL    6   almost_full asserted when count >= AF_LEVEL (1..FIFO_DEPTH)
//  AE_LEVEL    1   almost_empty asserted when count <= AE_LEVEL (0..FIFO_DEPTH-1)
// PORTS
//  clk           in   1              rising-edge clock
//  rst           in   1              asynchronous reset, active-high
//  cs            in   1              chip select; wr_en/rd_en/flush/clr_err ignored when 0
//  wr_en         in   1              write request
//  rd_en         in   1              read request
//  flush         in   1              synchronous flush (pointers/count to 0)
//  clr_err       in   1              synchronous clear of overflow/underflow
//  data_in       in   DATA_WIDTH     write data
//  data_out      out  DATA_WIDTH     read data
//  empty         out  1              count == 0
//  full          out  1              count == FIFO_DEPTH
//  almost_empty  out  1              count <= AE_LEVEL
//  almost_full   out  1              count >= AF_LEVEL
//  count         out  $clog2(FIFO_DEPTH)+1  current occupancy
//  overflow      out  1              sticky: write attempted while full and not read
//  underflow     out  1              sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst=1, async): wr_ptr=rd_ptr=0, count=0, data_out=0, overflow=underflow=0;
//    so empty=1, full=0, almost_empty=1, almost_full=0. Memory contents not reset.
//  - Pointers are $clog2(FIFO_DEPTH)+1 bits (extra wrap bit); index wraps DEPTH-1 -> 0.
//  - wr_acc = cs & wr_en & (!full | rd_acc); rd_acc = cs & rd_en & !empty.
//  - wr_acc: mem[wr_ptr]<=data_in, wr_ptr++. rd_acc: rd_ptr++.
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//  - Full + rd + wr in same cycle: both accepted, count stays FIFO_DEPTH, no overflow.
//  - Empty + rd + wr in same cycle: write accepted, read rejected, underflow set.
//  - cs&wr_en&!wr_acc -> overflow<=1; cs&rd_en&empty -> underflow<=1; data dropped/held.
//  - flush (cs=1) has priority over rd/wr in that cycle: ptrs=0, count=0; data_out held;
//    error flags unaffected. clr_err clears flags; a new error in same cycle wins (stays 1).
//  - Status flags are decoded from registered count: valid the cycle after the causing edge.
// CONFIGURATION
//  Macro UNIV_FIFO_FWFT_EN:
//  - Undefined (standard mode): data_out registered; on the edge where rd_acc=1,
//    data_out<=mem[rd_ptr]; otherwise data_out holds. Read latency 1 cycle.
//  - Defined (first-word-fall-through): data_out = mem[rd_ptr] while !empty, 0 while empty;
//    head word visible with no read request; rd_acc pops it, next word appears same cycle
//    after the edge. Write-to-visible latency 1 cycle (entry to previously empty FIFO).
//    All other rules (count, flags, flush, errors) identical.
// STRUCTURE
//  - Package univ_fifo_pkg: ADDR_W=$clog2(FIFO_DEPTH), CNT_W=ADDR_W+1 helper functions,
//    parameter legality checks (power-of-two depth, threshold ranges) as elaboration errors.
//  - Sub-module univ_fifo_ram: DEPTH x WIDTH, 1 sync write port, 1 async read port.
//  - Top: pointer/count logic, flag decode, error registers, data_out register / FWFT mux.
// TESTING  (DEPTH=8, WIDTH=32, AF=6, AE=1; both macro settings)
//  1 Reset mid-traffic: write 3 words, assert rst -> count=0, empty=1, data_out=0 at once.
//  2 Write 1,10,100 then 4 reads -> data_out 1,10,100, 4th read: data held 100, underflow=1.
//  3 Fill 9 writes of 2**i -> full=1 after 8, count=8, 9th (256) dropped, overflow=1;
//    8 reads return 1..128 in order; clr_err -> overflow=0.
//  4 Thresholds: count 1 -> almost_empty=1; count 2 -> 0; count 6 -> almost_full=1; 5 -> 0.
//  5 Full with simultaneous rd+wr of 0xA5 -> count stays 8, no overflow, 0xA5 read last.
//  6 Flush with rd_en=wr_en=1 at count 5 -> count=0, empty=1; wrap: 20 write/read pairs
//    past index 7 return data in order; cs=0 with wr_en/rd_en=1 -> no state change.

Source files
------------

// File: rtl/univ_fifo_pkg.sv
// Shared sizing helpers and parameter legality predicates for the universal sync FIFO.
package univ_fifo_pkg;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_ok(input int af, input int depth);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit ae_ok(input int ae, input int depth);
    return (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/univ_fifo_ram.sv
// FIFO storage: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port.
module univ_fifo_ram
  import univ_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [addr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [addr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately left unreset; occupancy logic guards stale entries.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/univ_sync_fifo_prog.sv
// Single-clock FIFO with fill count, programmable almost flags, sticky errors and flush.
// Define UNIV_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module univ_sync_fifo_prog
  import univ_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic                        flush,
  input  logic                        clr_err,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int ADDR_W = addr_w(FIFO_DEPTH);
  localparam int CNT_W  = cnt_w(FIFO_DEPTH);

  if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (!af_ok(AF_LEVEL, FIFO_DEPTH)) begin : g_bad_af
    $error("AF_LEVEL must lie in 1..FIFO_DEPTH");
  end
  if (!ae_ok(AE_LEVEL, FIFO_DEPTH)) begin : g_bad_ae
    $error("AE_LEVEL must lie in 0..FIFO_DEPTH-1");
  end

  logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  fl, rd_acc, wr_acc, rd_go, wr_go;
  logic [DATA_WIDTH-1:0] head;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(FIFO_DEPTH));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign fl     = cs & flush;
  assign rd_acc = cs & rd_en & ~empty;
  assign wr_acc = cs & wr_en & (~full | rd_acc);
  assign rd_go  = rd_acc & ~fl;
  assign wr_go  = wr_acc & ~fl;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (fl) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_go) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (rd_go) rd_ptr_d = rd_ptr_q + CNT_W'(1);
      case ({wr_go, rd_go})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    // Clear first so an error raised in the same cycle survives the clear.
    if (cs & clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (~fl & cs & wr_en & ~wr_acc) overflow_d  = 1'b1;
    if (~fl & cs & rd_en & empty)   underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  univ_fifo_ram #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_go),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (head)
  );

`ifdef UNIV_FIFO_FWFT_EN
  assign data_out = empty ? '0 : head;
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_go) data_out_d = head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out_q <= '0;
    else     data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_univ_sync_fifo_prog.sv
// Directed bench for univ_sync_fifo_prog (DEPTH=8, WIDTH=32, AF=6, AE=1), either output mode.
module tb_univ_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst, cs, wr_en, rd_en, flush, clr_err;
  logic [31:0] data_in, data_out;
  logic        empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  univ_sync_fifo_prog dut (
    .clk          (clk),
    .rst          (rst),
    .cs           (cs),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .flush        (flush),
    .clr_err      (clr_err),
    .data_in      (data_in),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs, wr, rd, fl, clr;
    logic [3:0] cnt;
    logic       e, f, ae, af, ov, ud;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic c, w, r, f_, cl, input logic [3:0] n,
                              input logic e, f, ae, af, ov, ud);
    vec_t v;
    v.cs = c; v.wr = w; v.rd = r; v.fl = f_; v.clr = cl;
    v.cnt = n; v.e = e; v.f = f; v.ae = ae; v.af = af; v.ov = ov; v.ud = ud;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] status();
    return {count, empty, full, almost_empty, almost_full, overflow, underflow};
  endfunction

  task automatic cyc(input logic c, w, r, f, cl, input logic [31:0] d);
    cs = c; wr_en = w; rd_en = r; flush = f; clr_err = cl; data_in = d;
    @(posedge clk);
    #1;
    cs = 0; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; data_in = '0;
  endtask

  task automatic do_read(input string name, input logic [31:0] exp);
`ifdef UNIV_FIFO_FWFT_EN
    chk(name, data_out, exp);
    cyc(1, 0, 1, 0, 0, 0);
`else
    cyc(1, 0, 1, 0, 0, 0);
    chk(name, data_out, exp);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end, got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1; cs = 0; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; data_in = '0;

    tbl[0]  = mk(1,1,0,0,0, 4'd1, 0,0,1,0, 0,0);
    tbl[1]  = mk(1,1,0,0,0, 4'd2, 0,0,0,0, 0,0);
    tbl[2]  = mk(1,1,0,0,0, 4'd3, 0,0,0,0, 0,0);
    tbl[3]  = mk(1,1,0,0,0, 4'd4, 0,0,0,0, 0,0);
    tbl[4]  = mk(1,1,0,0,0, 4'd5, 0,0,0,0, 0,0);
    tbl[5]  = mk(1,1,0,0,0, 4'd6, 0,0,0,1, 0,0);
    tbl[6]  = mk(1,0,1,0,0, 4'd5, 0,0,0,0, 0,0);
    tbl[7]  = mk(0,1,1,1,1, 4'd5, 0,0,0,0, 0,0);
    tbl[8]  = mk(1,1,1,0,0, 4'd5, 0,0,0,0, 0,0);
    tbl[9]  = mk(1,1,1,1,0, 4'd0, 1,0,1,0, 0,0);
    tbl[10] = mk(1,0,1,0,0, 4'd0, 1,0,1,0, 0,1);
    tbl[11] = mk(1,0,0,0,1, 4'd0, 1,0,1,0, 0,0);
    tbl[12] = mk(1,1,1,0,0, 4'd1, 0,0,1,0, 0,1);
    tbl[13] = mk(1,0,1,0,1, 4'd0, 1,0,1,0, 0,0);
    tbl[14] = mk(1,0,1,0,1, 4'd0, 1,0,1,0, 0,1);
    tbl[15] = mk(1,1,0,0,0, 4'd1, 0,0,1,0, 0,1);
    tbl[16] = mk(1,0,0,1,0, 4'd0, 1,0,1,0, 0,1);
    tbl[17] = mk(1,0,0,0,1, 4'd0, 1,0,1,0, 0,0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", 32'(status()), 32'({4'd0, 6'b101000}));
    chk("reset_data", data_out, 32'h0);
    rst = 0;

    // Asynchronous reset in the middle of traffic.
    cyc(1, 1, 0, 0, 0, 32'h11);
    cyc(1, 1, 0, 0, 0, 32'h22);
    cyc(1, 1, 0, 0, 0, 32'h33);
    do_read("t1_read", 32'h11);
    #2 rst = 1;
    #1;
    chk("t1_async_status", 32'(status()), 32'({4'd0, 6'b101000}));
    chk("t1_async_data", data_out, 32'h0);
    @(posedge clk);
    #1 rst = 0;

    // Ordered reads, then a read from empty.
    cyc(1, 1, 0, 0, 0, 32'd1);
    cyc(1, 1, 0, 0, 0, 32'd10);
    cyc(1, 1, 0, 0, 0, 32'd100);
    do_read("t2_rd0", 32'd1);
    do_read("t2_rd1", 32'd10);
    do_read("t2_rd2", 32'd100);
    cyc(1, 0, 1, 0, 0, 0);
`ifdef UNIV_FIFO_FWFT_EN
    chk("t2_rd_empty_data", data_out, 32'd0);
`else
    chk("t2_rd_empty_data", data_out, 32'd100);
`endif
    chk("t2_underflow", 32'(underflow), 32'd1);
    cyc(1, 0, 0, 0, 1, 0);
    chk("t2_clr", 32'(underflow), 32'd0);

    // Fill past capacity.
    for (int i = 0; i < 9; i++) begin
      cyc(1, 1, 0, 0, 0, 32'd1 << i);
      if (i == 7) chk("t3_full_at_8", 32'({count, full, overflow}), 32'({4'd8, 2'b10}));
    end
    chk("t3_after_9th", 32'({count, full, overflow}), 32'({4'd8, 2'b11}));
    for (int i = 0; i < 8; i++) do_read($sformatf("t3_rd%0d", i), 32'd1 << i);
    chk("t3_empty", 32'(empty), 32'd1);
    cyc(1, 0, 0, 0, 1, 0);
    chk("t3_clr_ovf", 32'(overflow), 32'd0);

    // Simultaneous read and write while full.
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 32'h10 + 32'(i));
    chk("t5_full", 32'(full), 32'd1);
`ifdef UNIV_FIFO_FWFT_EN
    chk("t5_rdwr_data", data_out, 32'h10);
    cyc(1, 1, 1, 0, 0, 32'hA5);
`else
    cyc(1, 1, 1, 0, 0, 32'hA5);
    chk("t5_rdwr_data", data_out, 32'h10);
`endif
    chk("t5_cnt_ovf", 32'({count, full, overflow}), 32'({4'd8, 2'b10}));
    for (int i = 1; i < 8; i++) do_read($sformatf("t5_rd%0d", i), 32'h10 + 32'(i));
    do_read("t5_rd_a5", 32'hA5);
    chk("t5_empty", 32'(empty), 32'd1);

    // Thresholds, chip select, flush and error-flag rules.
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].cs, tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].clr, 32'hC0 + 32'(i));
      chk($sformatf("vec%0d_status", i), 32'(status()),
          32'({tbl[i].cnt, tbl[i].e, tbl[i].f, tbl[i].ae, tbl[i].af, tbl[i].ov, tbl[i].ud}));
    end

    // Pointer wrap across many passes of the index.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 0, 0, 0, 32'h1000 + 32'(i));
      do_read($sformatf("wrap%0d", i), 32'h1000 + 32'(i));
    end
    chk("wrap_end_status", 32'(status()), 32'({4'd0, 6'b101000}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
